uart_pkt_parser: RTL and testbench

- Sits directly downstream of the UART receiver; consumes its byte stream (rx_byte qualified by a one-cycle rx_done pulse).
- Frames bytes into command packets: SYNC, CMD, LEN, LEN payload bytes, CHK.
- Writes payload bytes out through a simple write port into a consumer-owned buffer.
- Reports each completed packet as valid or errored, with an inter-byte timeout so a truncated packet never hangs the parser.

---
 rtl/uart_pkt_pkg.sv | 19 +
 rtl/uart_pkt_parser.sv | 160 ++++++++++++++++
 tb/tb_uart_pkt_parser.sv | 222 ++++++++++++++++++++++
 3 files changed

// File: rtl/uart_pkt_pkg.sv
// Shared types and constants for the UART command-packet parser.
package uart_pkt_pkg;

    typedef enum logic [2:0] {
        StHunt,
        StCmd,
        StLen,
        StPayload,
        StChk
    } state_t;

    localparam logic [1:0] ERR_NONE    = 2'd0;
    localparam logic [1:0] ERR_CHK     = 2'd1;
    localparam logic [1:0] ERR_LEN     = 2'd2;
    localparam logic [1:0] ERR_TIMEOUT = 2'd3;

    localparam logic [7:0] SYNC_BYTE_DEFAULT = 8'hAA;

endpackage

// File: rtl/uart_pkt_parser.sv
// Frames the UART byte stream into SYNC/CMD/LEN/payload/CHK packets, writes payload out
// and reports each packet as valid or errored, with an inter-byte timeout.
module uart_pkt_parser
    import uart_pkt_pkg::*;
#(
    parameter logic [7:0]  SYNC_BYTE    = SYNC_BYTE_DEFAULT,
    parameter int unsigned MAX_LEN      = 16,
    parameter int unsigned TIMEOUT_CLKS = 208320
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] rx_byte,
    input  logic       rx_done,
    output logic [7:0] pkt_cmd,
    output logic [7:0] pkt_len,
    output logic       pl_we,
    output logic [7:0] pl_addr,
    output logic [7:0] pl_data,
    output logic       pkt_valid,
    output logic       pkt_err,
    output logic [1:0] err_code,
    output logic       busy
);

    localparam int unsigned     CNT_W     = $clog2(TIMEOUT_CLKS);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    // Sampled one edge early so the error pulse lands TIMEOUT_CLKS-1 clocks after the last byte.
    localparam logic [CNT_W-1:0] CNT_TERM = CNT_W'(TIMEOUT_CLKS - 2);
    localparam logic [7:0]       MAX_LEN_B = 8'(MAX_LEN);

    state_t           state_q, state_d;
    logic [7:0]       acc_q, acc_d;
    logic [7:0]       idx_q, idx_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [7:0]       cmd_sh_q, cmd_sh_d;
    logic [7:0]       len_sh_q, len_sh_d;
    logic [7:0]       pkt_cmd_q, pkt_cmd_d;
    logic [7:0]       pkt_len_q, pkt_len_d;
    logic             pl_we_q, pl_we_d;
    logic [7:0]       pl_addr_q, pl_addr_d;
    logic [7:0]       pl_data_q, pl_data_d;
    logic             valid_q, valid_d;
    logic             err_q, err_d;
    logic [1:0]       code_q, code_d;
    logic             timeout;

    always_comb begin
        state_d   = state_q;
        acc_d     = acc_q;
        idx_d     = idx_q;
        cmd_sh_d  = cmd_sh_q;
        len_sh_d  = len_sh_q;
        pkt_cmd_d = pkt_cmd_q;
        pkt_len_d = pkt_len_q;
        pl_we_d   = 1'b0;
        pl_addr_d = pl_addr_q;
        pl_data_d = pl_data_q;
        valid_d   = 1'b0;
        err_d     = 1'b0;
        code_d    = code_q;
        cnt_d     = (state_q == StHunt || rx_done) ? '0 : cnt_q + CNT_ONE;
        // A byte arriving on the terminal cycle takes priority over the timeout.
        timeout   = (state_q != StHunt) && !rx_done && (cnt_q == CNT_TERM);

        if (timeout) begin
            err_d   = 1'b1;
            code_d  = ERR_TIMEOUT;
            state_d = StHunt;
            cnt_d   = '0;
        end else if (rx_done) begin
            unique case (state_q)
                StHunt: begin
                    if (rx_byte == SYNC_BYTE) state_d = StCmd;
                end
                StCmd: begin
                    cmd_sh_d = rx_byte;
                    acc_d    = rx_byte;
                    state_d  = StLen;
                end
                StLen: begin
                    if (rx_byte > MAX_LEN_B) begin
                        err_d   = 1'b1;
                        code_d  = ERR_LEN;
                        state_d = StHunt;
                    end else begin
                        len_sh_d = rx_byte;
                        acc_d    = acc_q ^ rx_byte;
                        idx_d    = 8'd0;
                        state_d  = (rx_byte == 8'd0) ? StChk : StPayload;
                    end
                end
                StPayload: begin
                    pl_we_d   = 1'b1;
                    pl_addr_d = idx_q;
                    pl_data_d = rx_byte;
                    acc_d     = acc_q ^ rx_byte;
                    idx_d     = idx_q + 8'd1;
                    if (idx_q == len_sh_q - 8'd1) state_d = StChk;
                end
                StChk: begin
                    if (rx_byte == acc_q) begin
                        valid_d   = 1'b1;
                        pkt_cmd_d = cmd_sh_q;
                        pkt_len_d = len_sh_q;
                    end else begin
                        err_d  = 1'b1;
                        code_d = ERR_CHK;
                    end
                    state_d = StHunt;
                end
                default: state_d = StHunt;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= StHunt;
            acc_q     <= '0;
            idx_q     <= '0;
            cnt_q     <= '0;
            cmd_sh_q  <= '0;
            len_sh_q  <= '0;
            pkt_cmd_q <= '0;
            pkt_len_q <= '0;
            pl_we_q   <= 1'b0;
            pl_addr_q <= '0;
            pl_data_q <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
            code_q    <= ERR_NONE;
        end else begin
            state_q   <= state_d;
            acc_q     <= acc_d;
            idx_q     <= idx_d;
            cnt_q     <= cnt_d;
            cmd_sh_q  <= cmd_sh_d;
            len_sh_q  <= len_sh_d;
            pkt_cmd_q <= pkt_cmd_d;
            pkt_len_q <= pkt_len_d;
            pl_we_q   <= pl_we_d;
            pl_addr_q <= pl_addr_d;
            pl_data_q <= pl_data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
            code_q    <= code_d;
        end
    end

    assign pkt_cmd   = pkt_cmd_q;
    assign pkt_len   = pkt_len_q;
    assign pl_we     = pl_we_q;
    assign pl_addr   = pl_addr_q;
    assign pl_data   = pl_data_q;
    assign pkt_valid = valid_q;
    assign pkt_err   = err_q;
    assign err_code  = code_q;
    assign busy      = (state_q != StHunt);

endmodule

// File: tb/tb_uart_pkt_parser.sv
// Directed and randomized packet traffic checked against a packet-level model.
module tb_uart_pkt_parser;
    import uart_pkt_pkg::*;

    localparam int unsigned T    = 16;
    localparam int unsigned MAXL = 16;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] rx_byte;
    logic       rx_done;
    logic [7:0] pkt_cmd, pkt_len, pl_addr, pl_data;
    logic       pl_we, pkt_valid, pkt_err, busy;
    logic [1:0] err_code;

    uart_pkt_parser #(
        .SYNC_BYTE   (8'hAA),
        .MAX_LEN     (MAXL),
        .TIMEOUT_CLKS(T)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .rx_byte  (rx_byte),
        .rx_done  (rx_done),
        .pkt_cmd  (pkt_cmd),
        .pkt_len  (pkt_len),
        .pl_we    (pl_we),
        .pl_addr  (pl_addr),
        .pl_data  (pl_data),
        .pkt_valid(pkt_valid),
        .pkt_err  (pkt_err),
        .err_code (err_code),
        .busy     (busy)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;

    // Model of the sticky outputs.
    logic [7:0] exp_cmd  = 8'd0;
    logic [7:0] exp_len  = 8'd0;
    logic [1:0] exp_code = ERR_NONE;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [7:0] pkt_xor(input logic [7:0] cmd, input logic [7:0] len,
                                           input logic [7:0] pl[$]);
        logic [7:0] x = cmd ^ len;
        foreach (pl[i]) x ^= pl[i];
        return x;
    endfunction

    task automatic check_zero(input string tag);
        check({tag, ".cmd"}, 32'(pkt_cmd), 0);
        check({tag, ".len"}, 32'(pkt_len), 0);
        check({tag, ".we"}, 32'(pl_we), 0);
        check({tag, ".addr"}, 32'(pl_addr), 0);
        check({tag, ".data"}, 32'(pl_data), 0);
        check({tag, ".valid"}, 32'(pkt_valid), 0);
        check({tag, ".err"}, 32'(pkt_err), 0);
        check({tag, ".code"}, 32'(err_code), 0);
        check({tag, ".busy"}, 32'(busy), 0);
    endtask

    // Called at #1 after an edge; leaves the bench at #1 after the edge that sampled the byte.
    task automatic send(input string tag, input logic [7:0] b, input int gap,
                        input bit e_we, input logic [7:0] e_addr, input logic [7:0] e_data,
                        input bit e_v, input bit e_e, input bit e_busy);
        for (int i = 0; i < gap; i++) begin
            @(posedge clk); #1;
            check({tag, ".idle_we"}, 32'(pl_we), 0);
            check({tag, ".idle_valid"}, 32'(pkt_valid), 0);
            check({tag, ".idle_err"}, 32'(pkt_err), 0);
        end
        rx_byte = b;
        rx_done = 1'b1;
        @(posedge clk); #1;
        rx_done = 1'b0;
        rx_byte = 8'($urandom);
        check({tag, ".we"}, 32'(pl_we), 32'(e_we));
        if (e_we) begin
            check({tag, ".addr"}, 32'(pl_addr), 32'(e_addr));
            check({tag, ".data"}, 32'(pl_data), 32'(e_data));
        end
        check({tag, ".valid"}, 32'(pkt_valid), 32'(e_v));
        check({tag, ".err"}, 32'(pkt_err), 32'(e_e));
        check({tag, ".busy"}, 32'(busy), 32'(e_busy));
        check({tag, ".pkt_cmd"}, 32'(pkt_cmd), 32'(exp_cmd));
        check({tag, ".pkt_len"}, 32'(pkt_len), 32'(exp_len));
        check({tag, ".code"}, 32'(err_code), 32'(exp_code));
    endtask

    task automatic send_pkt(input string tag, input logic [7:0] cmd, input logic [7:0] len,
                            input logic [7:0] pl[$], input logic [7:0] chk, input int gapmax);
        logic [7:0] x;
        send({tag, ".sync"}, 8'hAA, $urandom_range(gapmax, 0), 0, 0, 0, 0, 0, 1);
        send({tag, ".cmd"}, cmd, $urandom_range(gapmax, 0), 0, 0, 0, 0, 0, 1);
        if (32'(len) > MAXL) begin
            exp_code = ERR_LEN;
            send({tag, ".len_err"}, len, $urandom_range(gapmax, 0), 0, 0, 0, 0, 1, 0);
            return;
        end
        send({tag, ".len"}, len, $urandom_range(gapmax, 0), 0, 0, 0, 0, 0, 1);
        for (int i = 0; i < int'(len); i++)
            send({tag, ".pl"}, pl[i], $urandom_range(gapmax, 0), 1, 8'(i), pl[i], 0, 0, 1);
        x = pkt_xor(cmd, len, pl);
        if (chk == x) begin
            exp_cmd = cmd;
            exp_len = len;
            send({tag, ".chk_ok"}, chk, $urandom_range(gapmax, 0), 0, 0, 0, 1, 0, 0);
        end else begin
            exp_code = ERR_CHK;
            send({tag, ".chk_bad"}, chk, $urandom_range(gapmax, 0), 0, 0, 0, 0, 1, 0);
        end
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog total=%0d bad=%0d", total, bad);
        $fatal(1);
    end

    initial begin
        logic [7:0] q[$];
        logic [7:0] cmd, len, chk, nb;
        int         kind;

        rst     = 1'b1;
        rx_done = 1'b0;
        rx_byte = 8'h00;
        repeat (2) @(posedge clk);
        #1;
        check_zero("reset");
        rst = 1'b0;

        q = {8'h10, 8'h20};
        send_pkt("valid", 8'h01, 8'h02, q, 8'h33, 0);

        q = {8'h7E};
        send_pkt("badchk", 8'h05, 8'h01, q, 8'h00, 0);

        q = {};
        send_pkt("toolong", 8'h01, 8'h11, q, 8'h00, 0);
        send_pkt("len0", 8'h01, 8'h00, q, 8'h01, 0);

        send("noise0", 8'h55, 0, 0, 0, 0, 0, 0, 0);
        send("noise1", 8'h00, 0, 0, 0, 0, 0, 0, 0);
        q = {8'hAA};
        send_pkt("syncdata", 8'h02, 8'h01, q, pkt_xor(8'h02, 8'h01, q), 0);

        // Silence after LEN-less header: error exactly T-1 clocks after the CMD byte.
        send("to.sync", 8'hAA, 1, 0, 0, 0, 0, 0, 1);
        send("to.cmd", 8'h03, 0, 0, 0, 0, 0, 0, 1);
        for (int n = 1; n < int'(T) - 1; n++) begin
            @(posedge clk); #1;
            check("to.wait_err", 32'(pkt_err), 0);
            check("to.wait_busy", 32'(busy), 1);
        end
        @(posedge clk); #1;
        exp_code = ERR_TIMEOUT;
        check("to.err", 32'(pkt_err), 1);
        check("to.code", 32'(err_code), 32'(exp_code));
        check("to.valid", 32'(pkt_valid), 0);
        check("to.busy", 32'(busy), 0);
        @(posedge clk); #1;
        check("to.err_pulse", 32'(pkt_err), 0);

        // Byte landing on the terminal cycle wins over the timeout.
        send("inj.sync", 8'hAA, 0, 0, 0, 0, 0, 0, 1);
        send("inj.cmd", 8'h03, 0, 0, 0, 0, 0, 0, 1);
        repeat (T - 2) @(posedge clk);
        #1;
        send("inj.len", 8'h00, 0, 0, 0, 0, 0, 0, 1);
        exp_cmd = 8'h03;
        exp_len = 8'h00;
        send("inj.chk", 8'h03, 0, 0, 0, 0, 1, 0, 0);

        // Reset in the middle of a packet.
        send("rm.sync", 8'hAA, 0, 0, 0, 0, 0, 0, 1);
        send("rm.cmd", 8'h01, 0, 0, 0, 0, 0, 0, 1);
        send("rm.len", 8'h04, 0, 0, 0, 0, 0, 0, 1);
        send("rm.pl0", 8'h11, 0, 1, 8'h00, 8'h11, 0, 0, 1);
        rst = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0;
        exp_cmd  = 8'd0;
        exp_len  = 8'd0;
        exp_code = ERR_NONE;
        check_zero("rm.reset");
        q = {8'hDE, 8'hAD, 8'hBE};
        send_pkt("rm.after", 8'h42, 8'h03, q, pkt_xor(8'h42, 8'h03, q), 1);

        for (int p = 0; p < 40; p++) begin
            for (int k = 0; k < int'($urandom_range(2, 0)); k++) begin
                nb = 8'($urandom);
                if (nb == 8'hAA) nb = 8'h55;
                send("rnd.noise", nb, $urandom_range(2, 0), 0, 0, 0, 0, 0, 0);
            end
            kind = int'($urandom_range(5, 0));
            cmd  = 8'($urandom);
            len  = (kind == 0) ? 8'($urandom_range(255, MAXL + 1)) : 8'($urandom_range(MAXL, 0));
            q = {};
            if (kind != 0)
                for (int i = 0; i < int'(len); i++) q.push_back(8'($urandom));
            chk = pkt_xor(cmd, len, q);
            if (kind == 1) chk = chk ^ 8'($urandom_range(255, 1));
            send_pkt("rnd", cmd, len, q, chk, 3);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
